// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-4 word demultiplexer.
// Holds the default word width, the channel-select encoding and the counter width.
package demux_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_C = 2'd2,
        CH_D = 2'd3
    } ch_sel_t;

endpackage

// File: rtl/demux_chan.sv
// One output channel: a one-entry holding register with a valid/ready handshake.
// Ports: clk/rst (sync, active-high), load/din from the steering logic,
// ready from the consumer, data/valid to the consumer, free = can take a word
// this cycle, cnt = delivery counter (only when DEMUX_STATS_EN is defined).
module demux_chan
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              free
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0]  cnt
`endif
);

    logic drain;

    assign drain = valid && ready;
    // A full channel can still accept when its word leaves in the same cycle.
    assign free  = !valid || ready;

    // Data is never cleared after delivery; only valid qualifies it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= din;
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux1to4_16b.sv
// Registered 1-to-4 demultiplexer: steers one word into channel a/b/c/d by {in1,in0}.
// Ports: clkpos, rst (sync, active-high), vdd/vss (no logic), in/in0/in1/in_valid/in_ready
// producer side, a..d + x_valid/x_ready per channel; cnt_a..cnt_d with DEMUX_STATS_EN.
module demux1to4_16b
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clkpos,
    input  logic              rst,
    input  logic              vdd,
    input  logic              vss,
    input  logic [DATA_W-1:0] in,
    input  logic              in0,
    input  logic              in1,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic              a_valid,
    output logic              b_valid,
    output logic              c_valid,
    output logic              d_valid,
    input  logic              a_ready,
    input  logic              b_ready,
    input  logic              c_ready,
    input  logic              d_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b,
    output logic [CNT_W-1:0]  cnt_c,
    output logic [CNT_W-1:0]  cnt_d
`endif
);

    // Supply pins exist only for netlist compatibility.
    logic unused_supply;
    assign unused_supply = vdd ^ vss;

    ch_sel_t           sel;
    logic [3:0]        ld;
    logic [3:0]        free;
    logic [3:0]        vld;
    logic [3:0]        rdy;
    logic [DATA_W-1:0] dat [4];

    assign sel = ch_sel_t'({in1, in0});
    assign rdy = {d_ready, c_ready, b_ready, a_ready};

    always_comb begin
        ld       = 4'b0000;
        in_ready = 1'b0;
        case (sel)
            CH_A: in_ready = free[0];
            CH_B: in_ready = free[1];
            CH_C: in_ready = free[2];
            CH_D: in_ready = free[3];
            default: in_ready = 1'b0;
        endcase
        if (in_valid && in_ready) begin
            ld = 4'b0001 << sel;
        end
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt [4];
`endif

    for (genvar i = 0; i < 4; i++) begin : g_chan
        demux_chan #(
            .DATA_W (DATA_W)
        ) u_chan (
            .clk   (clkpos),
            .rst   (rst),
            .load  (ld[i]),
            .din   (in),
            .ready (rdy[i]),
            .data  (dat[i]),
            .valid (vld[i]),
            .free  (free[i])
`ifdef DEMUX_STATS_EN
            ,
            .cnt   (cnt[i])
`endif
        );
    end

    assign a       = dat[0];
    assign b       = dat[1];
    assign c       = dat[2];
    assign d       = dat[3];
    assign a_valid = vld[0];
    assign b_valid = vld[1];
    assign c_valid = vld[2];
    assign d_valid = vld[3];

`ifdef DEMUX_STATS_EN
    assign cnt_a = cnt[0];
    assign cnt_b = cnt[1];
    assign cnt_c = cnt[2];
    assign cnt_d = cnt[3];
`endif

endmodule

// File: tb/tb_demux1to4_16b.sv
// Self-checking bench for demux1to4_16b with per-channel scoreboard queues.
// Covers reset, full boundary, drain+reload, streaming, reset override and random traffic.
module tb_demux1to4_16b;

    logic        clkpos = 1'b0;
    logic        rst;
    logic        vdd = 1'b1;
    logic        vss = 1'b0;
    logic [15:0] in;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, c, d;
    logic        a_valid, b_valid, c_valid, d_valid;
    logic [3:0]  rdy;
`ifdef DEMUX_STATS_EN
    logic [7:0]  cnt_a, cnt_b, cnt_c, cnt_d;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] q [4][$];
    logic [7:0]  mcnt [4];

    logic [3:0]  vv;
    logic [15:0] dd [4];
    logic [7:0]  cc [4];

    assign vv    = {d_valid, c_valid, b_valid, a_valid};
    assign dd[0] = a;
    assign dd[1] = b;
    assign dd[2] = c;
    assign dd[3] = d;
`ifdef DEMUX_STATS_EN
    assign cc[0] = cnt_a;
    assign cc[1] = cnt_b;
    assign cc[2] = cnt_c;
    assign cc[3] = cnt_d;
`else
    assign cc[0] = 8'd0;
    assign cc[1] = 8'd0;
    assign cc[2] = 8'd0;
    assign cc[3] = 8'd0;
`endif

    always #5 clkpos = ~clkpos;

    demux1to4_16b dut (
        .clkpos   (clkpos),
        .rst      (rst),
        .vdd      (vdd),
        .vss      (vss),
        .in       (in),
        .in0      (sel[0]),
        .in1      (sel[1]),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .c_valid  (c_valid),
        .d_valid  (d_valid),
        .a_ready  (rdy[0]),
        .b_ready  (rdy[1]),
        .c_ready  (rdy[2]),
        .d_ready  (rdy[3])
`ifdef DEMUX_STATS_EN
        ,
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .cnt_c    (cnt_c),
        .cnt_d    (cnt_d)
`endif
    );

    task automatic tick();
        @(posedge clkpos);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in = 16'hFFFF; sel = 2'd0; in_valid = 1'b0; rdy = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (vv !== 4'b0000) begin
            bad++; $display("FAIL reset_valid got=%b exp=0000", vv);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dd[i] !== 16'h0000) begin
                bad++; $display("FAIL reset_data ch=%0d got=%h exp=0000", i, dd[i]);
            end
`ifdef DEMUX_STATS_EN
            total++;
            if (cc[i] !== 8'd0) begin
                bad++; $display("FAIL reset_cnt ch=%0d got=%0d exp=0", i, cc[i]);
            end
`endif
            mcnt[i] = 8'd0;
        end
    endtask

    task automatic test_full_boundary();
        in = 16'h1234; sel = 2'd2; in_valid = 1'b1; rdy = 4'b0000;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL fb_first_ready got=%b exp=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (c !== 16'h1234 || vv !== 4'b0100) begin
            bad++; $display("FAIL fb_load_c got=%h v=%b exp=1234 v=0100", c, vv);
        end
        in = 16'h1111; sel = 2'd2; in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL fb_blocked got=%b exp=0", in_ready);
        end
        tick();
        total++;
        if (c !== 16'h1234) begin
            bad++; $display("FAIL fb_no_overwrite got=%h exp=1234", c);
        end
        in = 16'hBEEF; sel = 2'd0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL fb_other_ready got=%b exp=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (a !== 16'hBEEF || vv !== 4'b0101) begin
            bad++; $display("FAIL fb_load_a got=%h v=%b exp=beef v=0101", a, vv);
        end
    endtask

    task automatic test_drain_reload();
        rdy = 4'b0100; in = 16'h5A5A; sel = 2'd2; in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL dr_ready got=%b exp=1", in_ready);
        end
        tick();
        mcnt[2] = mcnt[2] + 8'd1;
        in_valid = 1'b0; rdy = 4'b0000;
        #1;
        total++;
        if (c !== 16'h5A5A || c_valid !== 1'b1) begin
            bad++; $display("FAIL dr_reload got=%h v=%b exp=5a5a v=1", c, c_valid);
        end
`ifdef DEMUX_STATS_EN
        total++;
        if (cnt_c !== 8'd1) begin
            bad++; $display("FAIL dr_cnt_c got=%0d exp=1", cnt_c);
        end
`endif
        rdy = 4'b1111;
        tick();
        mcnt[0] = mcnt[0] + 8'd1;
        mcnt[2] = mcnt[2] + 8'd1;
        rdy = 4'b0000;
        #1;
        total++;
        if (vv !== 4'b0000) begin
            bad++; $display("FAIL dr_flush got=%b exp=0000", vv);
        end
    endtask

    task automatic test_stream();
        int accepts;
        accepts = 0;
        rdy = 4'b1000; sel = 2'd3; in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in = 16'(i);
            #1;
            if (in_ready === 1'b1) accepts++;
            tick();
            total++;
            if (d !== 16'(i) || d_valid !== 1'b1) begin
                bad++; $display("FAIL st_word i=%0d got=%h v=%b", i, d, d_valid);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (accepts !== 256) begin
            bad++; $display("FAIL st_accepts got=%0d exp=256", accepts);
        end
        total++;
        if (d_valid !== 1'b0) begin
            bad++; $display("FAIL st_drained got=%b exp=0", d_valid);
        end
`ifdef DEMUX_STATS_EN
        total++;
        if (cnt_d !== 8'd0) begin
            bad++; $display("FAIL st_cnt_wrap got=%0d exp=0", cnt_d);
        end
`endif
        rdy = 4'b0000;
    endtask

    task automatic test_reset_override();
        rdy = 4'b0000; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i); in = 16'hA000 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        total++;
        if (vv !== 4'b1111) begin
            bad++; $display("FAIL ro_fill got=%b exp=1111", vv);
        end
        rdy = 4'b1111; sel = 2'd1; in = 16'h7777; in_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; rdy = 4'b0000; in_valid = 1'b0;
        #1;
        total++;
        if (vv !== 4'b0000) begin
            bad++; $display("FAIL ro_valid got=%b exp=0000", vv);
        end
        for (int i = 0; i < 4; i++) begin
            mcnt[i] = 8'd0;
            total++;
            if (dd[i] !== 16'h0000 || cc[i] !== 8'd0) begin
                bad++; $display("FAIL ro_clear ch=%0d got=%h cnt=%0d exp=0", i, dd[i], cc[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_w;
        logic        exp_rdy;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 10000 + 8; cyc++) begin
            if (cyc < 10000) begin
                rdy = 4'($urandom_range(0, 15));
                if (!in_valid && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in = 16'($urandom);
                    sel = 2'($urandom_range(0, 3));
                end
            end else begin
                rdy = 4'b1111;
                in_valid = 1'b0;
            end
            #1;
            exp_rdy = (q[sel].size() == 0) || rdy[sel];
            total++;
            if (in_ready !== exp_rdy) begin
                bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
            end
            for (int ch = 0; ch < 4; ch++) begin
                total++;
                if (vv[ch] !== (q[ch].size() != 0)) begin
                    bad++; $display("FAIL rnd_valid cyc=%0d ch=%0d got=%b exp=%0d", cyc, ch, vv[ch], q[ch].size());
                end
                if (vv[ch] && rdy[ch] && q[ch].size() != 0) begin
                    exp_w = q[ch].pop_front();
                    mcnt[ch] = mcnt[ch] + 8'd1;
                    total++;
                    if (dd[ch] !== exp_w) begin
                        bad++; $display("FAIL rnd_data cyc=%0d ch=%0d got=%h exp=%h", cyc, ch, dd[ch], exp_w);
                    end
                end
            end
            if (in_valid && exp_rdy) q[sel].push_back(in);
            tick();
            if (in_valid && exp_rdy) in_valid = 1'b0;
        end
        for (int ch = 0; ch < 4; ch++) begin
            total++;
            if (q[ch].size() != 0 || vv[ch] !== 1'b0) begin
                bad++; $display("FAIL rnd_leftover ch=%0d q=%0d v=%b", ch, q[ch].size(), vv[ch]);
            end
`ifdef DEMUX_STATS_EN
            total++;
            if (cc[ch] !== mcnt[ch]) begin
                bad++; $display("FAIL rnd_cnt ch=%0d got=%0d exp=%0d", ch, cc[ch], mcnt[ch]);
            end
`endif
        end
        rdy = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_full_boundary();
        test_drain_reload();
        test_stream();
        test_reset_override();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
